ex_stage: RTL and testbench

//  Execute stage of the 5-stage RV32I pipeline, directly downstream of the ID/EX register.
//  - Consumes the ID/EX register outputs and forwards operands from MEM/WB.
//  - Computes the ALU result and resolves branches/jumps (redirect to IF).
//  - Registers results into the EX/MEM pipeline register.
//  - Optionally hosts an iterative M-extension unit that stalls the pipeline.

---
 rtl/rv_pkg.sv | 83 ++++++++
 rtl/muldiv_iter.sv | 141 ++++++++++++++
 rtl/ex_stage.sv | 196 +++++++++++++++++++
 tb/tb_ex_stage.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I execute stage: ALUop and funct3 encodings,
// EX_ctrl bit positions, muldiv state enum and small datapath helpers.
package rv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;

    // ALUop encodings from the decoder
    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpFunct  = 2'b10;

    // ALU funct3
    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3SrlSra = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    // M-extension funct3
    localparam logic [2:0] F3Mul    = 3'b000;
    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;
    localparam logic [2:0] F3Div    = 3'b100;
    localparam logic [2:0] F3Divu   = 3'b101;
    localparam logic [2:0] F3Rem    = 3'b110;
    localparam logic [2:0] F3Remu   = 3'b111;

    // EX_ctrl = {Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,Jump,return,PCsel,ins30}
    localparam int unsigned CtrlBranch   = 9;
    localparam int unsigned CtrlMemRead  = 8;
    localparam int unsigned CtrlMemtoReg = 7;
    localparam int unsigned CtrlMemWrite = 6;
    localparam int unsigned CtrlAluSrc   = 5;
    localparam int unsigned CtrlRegWrite = 4;
    localparam int unsigned CtrlJump     = 3;
    localparam int unsigned CtrlReturn   = 2;
    localparam int unsigned CtrlPcSel    = 1;
    localparam int unsigned CtrlIns30    = 0;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdBusy = 2'd1,
        MdDone = 2'd2
    } md_state_e;

    // MEM beats WB beats the register file; x0 never forwards.
    function automatic logic [XLEN-1:0] fwd_select(
        input logic [RADDR_W-1:0] rs,
        input logic [XLEN-1:0]    rf_data,
        input logic               mem_we,
        input logic [RADDR_W-1:0] mem_rd,
        input logic [XLEN-1:0]    mem_data,
        input logic               wb_we,
        input logic [RADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]    wb_data
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
            return mem_data;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    // Two's-complement magnitude when neg is set.
    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, signs fixed up when the result is presented in DONE.
module muldiv_iter
    import rv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    md_state_e       state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;       // product high / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;       // product low / quotient (dividend shifts out)
    logic [XLEN-1:0] mcand_q, mcand_d; // multiplicand or divisor magnitude
    logic            neg_q, neg_d;     // product / quotient must be negated
    logic            nega_q, nega_d;   // remainder must be negated
    logic            divz_q, divz_d;
    logic [XLEN-1:0] dvd_q, dvd_d;     // original dividend for the divide-by-zero remainder

    logic            a_sgn, b_sgn, neg_a, neg_b;
    logic [XLEN:0]   mul_sum, rem_shift;
    logic [XLEN-1:0] rem_sub;
    logic            rem_ge;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo, rem;

    assign a_sgn = (op_i == F3Mulh) || (op_i == F3Mulhsu) || (op_i == F3Div) || (op_i == F3Rem);
    assign b_sgn = (op_i == F3Mulh) || (op_i == F3Div) || (op_i == F3Rem);
    assign neg_a = a_sgn & a_i[XLEN-1];
    assign neg_b = b_sgn & b_i[XLEN-1];

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign rem_shift = {hi_q, lo_q[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, mcand_q};
    assign rem_sub   = rem_shift[XLEN-1:0] - mcand_q;

    // Control FSM plus one multiply or divide step per BUSY cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        nega_d  = nega_q;
        divz_d  = divz_q;
        dvd_d   = dvd_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            MdIdle: begin
                if (start_i) begin
                    stall_o = 1'b1;
                    state_d = MdBusy;
                    cnt_d   = '0;
                    op_d    = op_i;
                    hi_d    = '0;
                    lo_d    = abs_if(a_i, neg_a);
                    mcand_d = abs_if(b_i, neg_b);
                    neg_d   = neg_a ^ neg_b;
                    nega_d  = neg_a;
                    divz_d  = (b_i == '0);
                    dvd_d   = a_i;
                end
            end
            MdBusy: begin
                stall_o = 1'b1;
                if (op_q[2]) begin
                    hi_d = rem_ge ? rem_sub : rem_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], rem_ge};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = MdDone;
                end
            end
            MdDone: begin
                done_o  = 1'b1;
                state_d = MdIdle;
            end
            default: state_d = MdIdle;
        endcase
    end

    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? (~prod + 1'b1) : prod;
    assign quo    = neg_q ? (~lo_q + 1'b1) : lo_q;
    assign rem    = nega_q ? (~hi_q + 1'b1) : hi_q;

    // Signed fix-up and divide-by-zero handling of the finished iteration.
    always_comb begin
        result_o = '0;
        unique case (op_q)
            F3Mul:                       result_o = prod_s[XLEN-1:0];
            F3Mulh, F3Mulhsu, F3Mulhu:   result_o = prod_s[2*XLEN-1:XLEN];
            F3Div, F3Divu:               result_o = divz_q ? '1 : quo;
            F3Rem, F3Remu:               result_o = divz_q ? dvd_q : rem;
            default:                     result_o = '0;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            divz_q  <= 1'b0;
            dvd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            nega_q  <= nega_d;
            divz_q  <= divz_d;
            dvd_q   <= dvd_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register. Define RV_MULDIV_EN to add the iterative M-extension unit.
module ex_stage
    import rv_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [9:0]         EX_ctrl,
    input  logic [1:0]         EX_ALUop,
    input  logic [2:0]         EX_funct3,
    input  logic               EX_ins25,
    input  logic [XLEN-1:0]    EX_PC,
    input  logic [XLEN-1:0]    EX_PC_4,
    input  logic [XLEN-1:0]    EX_readdata1,
    input  logic [XLEN-1:0]    EX_readdata2,
    input  logic [XLEN-1:0]    EX_immediate,
    input  logic [RADDR_W-1:0] EX_rs1,
    input  logic [RADDR_W-1:0] EX_rs2,
    input  logic [RADDR_W-1:0] EX_rd,
    input  logic [RADDR_W-1:0] fwd_mem_rd,
    input  logic [RADDR_W-1:0] fwd_wb_rd,
    input  logic               fwd_mem_we,
    input  logic               fwd_wb_we,
    input  logic [XLEN-1:0]    fwd_mem_data,
    input  logic [XLEN-1:0]    fwd_wb_data,
    output logic               MEM_MemRead,
    output logic               MEM_MemWrite,
    output logic               MEM_MemtoReg,
    output logic               MEM_RegWrite,
    output logic [2:0]         MEM_funct3,
    output logic [XLEN-1:0]    MEM_ALUresult,
    output logic [XLEN-1:0]    MEM_writedata,
    output logic [RADDR_W-1:0] MEM_rd,
    output logic               pc_redirect,
    output logic [XLEN-1:0]    pc_target,
    output logic               stall
);

    logic branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic jump, ret, pc_sel, ins30;

    assign branch     = EX_ctrl[CtrlBranch];
    assign mem_read   = EX_ctrl[CtrlMemRead];
    assign mem_to_reg = EX_ctrl[CtrlMemtoReg];
    assign mem_write  = EX_ctrl[CtrlMemWrite];
    assign alu_src    = EX_ctrl[CtrlAluSrc];
    assign reg_write  = EX_ctrl[CtrlRegWrite];
    assign jump       = EX_ctrl[CtrlJump];
    assign ret        = EX_ctrl[CtrlReturn];
    assign pc_sel     = EX_ctrl[CtrlPcSel];
    assign ins30      = EX_ctrl[CtrlIns30];

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_result, ex_result;
    logic [4:0]      shamt;
    logic            br_taken;

    assign fwd_a = fwd_select(EX_rs1, EX_readdata1, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                              fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    assign fwd_b = fwd_select(EX_rs2, EX_readdata2, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                              fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    assign op_a  = pc_sel ? EX_PC : fwd_a;
    assign op_b  = alu_src ? EX_immediate : fwd_b;
    assign shamt = op_b[4:0];

    // Base ALU; immediate forms never subtract (ADDI shares funct3 with SUB).
    always_comb begin
        alu_result = '0;
        unique case (EX_ALUop)
            AluOpAdd:    alu_result = op_a + op_b;
            AluOpBranch: alu_result = op_a - op_b;
            AluOpFunct: begin
                unique case (EX_funct3)
                    F3AddSub: alu_result = (ins30 && !alu_src) ? (op_a - op_b) : (op_a + op_b);
                    F3Sll:    alu_result = op_a << shamt;
                    F3Slt:    alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    F3Sltu:   alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
                    F3Xor:    alu_result = op_a ^ op_b;
                    F3SrlSra: alu_result = ins30 ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
                    F3Or:     alu_result = op_a | op_b;
                    F3And:    alu_result = op_a & op_b;
                    default:  alu_result = '0;
                endcase
            end
            default:     alu_result = op_a + op_b;
        endcase
    end

    // Branch condition on the forwarded register values.
    always_comb begin
        br_taken = 1'b0;
        case (EX_funct3)
            F3Beq:   br_taken = (fwd_a == fwd_b);
            F3Bne:   br_taken = (fwd_a != fwd_b);
            F3Blt:   br_taken = ($signed(fwd_a) < $signed(fwd_b));
            F3Bge:   br_taken = ($signed(fwd_a) >= $signed(fwd_b));
            F3Bltu:  br_taken = (fwd_a < fwd_b);
            F3Bgeu:  br_taken = (fwd_a >= fwd_b);
            default: br_taken = 1'b0;
        endcase
    end

`ifdef RV_MULDIV_EN
    logic            is_mop, md_stall, md_done;
    logic [XLEN-1:0] md_result;

    assign is_mop = (EX_ALUop == AluOpFunct) && !alu_src && EX_ins25;

    muldiv_iter u_muldiv (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .start_i  (is_mop),
        .op_i     (EX_funct3),
        .a_i      (fwd_a),
        .b_i      (fwd_b),
        .stall_o  (md_stall),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // FSM leaves IDLE only via a clock edge, so gate the combinational IDLE stall in reset.
    assign stall     = md_stall & reset_n;
    assign ex_result = md_done ? md_result : alu_result;
`else
    logic unused_ins25;
    assign unused_ins25 = EX_ins25;
    assign stall        = 1'b0;
    assign ex_result    = alu_result;
`endif

    assign pc_redirect = reset_n & ~stall & ((branch & br_taken) | jump | ret);
    assign pc_target   = ret ? ((fwd_a + EX_immediate) & ~XLEN'(1)) : (EX_PC + EX_immediate);

    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               reg_write_q, reg_write_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [XLEN-1:0]    alu_res_q, alu_res_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [RADDR_W-1:0] rd_q, rd_d;

    // EX/MEM next state: a stall inserts a bubble and holds the data fields.
    always_comb begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        funct3_d     = funct3_q;
        alu_res_d    = alu_res_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        if (!stall) begin
            mem_read_d   = mem_read;
            mem_write_d  = mem_write;
            mem_to_reg_d = mem_to_reg;
            reg_write_d  = reg_write;
            funct3_d     = EX_funct3;
            alu_res_d    = (jump || ret) ? EX_PC_4 : ex_result;
            wdata_d      = fwd_b;
            rd_d         = EX_rd;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            funct3_q     <= '0;
            alu_res_q    <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
        end else begin
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            funct3_q     <= funct3_d;
            alu_res_q    <= alu_res_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
        end
    end

    assign MEM_MemRead   = mem_read_q;
    assign MEM_MemWrite  = mem_write_q;
    assign MEM_MemtoReg  = mem_to_reg_q;
    assign MEM_RegWrite  = reg_write_q;
    assign MEM_funct3    = funct3_q;
    assign MEM_ALUresult = alu_res_q;
    assign MEM_writedata = wdata_q;
    assign MEM_rd        = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized instructions
// compared against a behavioural model. M-extension cases run when RV_MULDIV_EN is defined.
module tb_ex_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [9:0]  EX_ctrl;
    logic [1:0]  EX_ALUop;
    logic [2:0]  EX_funct3;
    logic        EX_ins25;
    logic [31:0] EX_PC, EX_PC_4, EX_readdata1, EX_readdata2, EX_immediate;
    logic [4:0]  EX_rs1, EX_rs2, EX_rd, fwd_mem_rd, fwd_wb_rd;
    logic        fwd_mem_we, fwd_wb_we;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_ALUresult, MEM_writedata;
    logic [4:0]  MEM_rd;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        stall;

    always #5 clock = ~clock;

    ex_stage dut (
        .clock(clock), .reset_n(reset_n), .EX_ctrl(EX_ctrl), .EX_ALUop(EX_ALUop),
        .EX_funct3(EX_funct3), .EX_ins25(EX_ins25), .EX_PC(EX_PC), .EX_PC_4(EX_PC_4),
        .EX_readdata1(EX_readdata1), .EX_readdata2(EX_readdata2), .EX_immediate(EX_immediate),
        .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd), .fwd_mem_rd(fwd_mem_rd),
        .fwd_wb_rd(fwd_wb_rd), .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
        .MEM_funct3(MEM_funct3), .MEM_ALUresult(MEM_ALUresult), .MEM_writedata(MEM_writedata),
        .MEM_rd(MEM_rd), .pc_redirect(pc_redirect), .pc_target(pc_target), .stall(stall)
    );

    typedef struct {
        logic        branch, memread, memtoreg, memwrite, alusrc, regwrite, jump, ret, pcsel, ins30;
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        ins25;
        logic [31:0] pc, pc4, rd1, rd2, imm, mdata, wdata;
        logic [4:0]  rs1, rs2, rd, mrd, wrd;
        logic        mwe, wwe;
    } stim_t;

    int n_checks = 0;
    int n_pass   = 0;
    logic        obs_redirect;
    logic [31:0] obs_target;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic stim_t nop_stim();
        stim_t s;
        {s.branch, s.memread, s.memtoreg, s.memwrite, s.alusrc} = '0;
        {s.regwrite, s.jump, s.ret, s.pcsel, s.ins30, s.ins25, s.mwe, s.wwe} = '0;
        s.aluop = 2'b00; s.f3 = 3'b000;
        s.pc = 32'h0; s.pc4 = 32'h4; s.rd1 = '0; s.rd2 = '0; s.imm = '0;
        s.mdata = '0; s.wdata = '0;
        s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3; s.mrd = '0; s.wrd = '0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        EX_ctrl = {s.branch, s.memread, s.memtoreg, s.memwrite, s.alusrc,
                   s.regwrite, s.jump, s.ret, s.pcsel, s.ins30};
        EX_ALUop = s.aluop; EX_funct3 = s.f3; EX_ins25 = s.ins25;
        EX_PC = s.pc; EX_PC_4 = s.pc4; EX_readdata1 = s.rd1; EX_readdata2 = s.rd2;
        EX_immediate = s.imm; EX_rs1 = s.rs1; EX_rs2 = s.rs2; EX_rd = s.rd;
        fwd_mem_rd = s.mrd; fwd_mem_we = s.mwe; fwd_mem_data = s.mdata;
        fwd_wb_rd = s.wrd; fwd_wb_we = s.wwe; fwd_wb_data = s.wdata;
    endtask

    // Reference model, straight from the instruction semantics.
    function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf,
                                          input stim_t s);
        if (rs == 0) return rf;
        if (s.mwe && s.mrd == rs) return s.mdata;
        if (s.wwe && s.wrd == rs) return s.wdata;
        return rf;
    endfunction

    function automatic logic [31:0] m_result(input stim_t s);
        logic [31:0] a, b;
        a = s.pcsel ? s.pc : m_fwd(s.rs1, s.rd1, s);
        b = s.alusrc ? s.imm : m_fwd(s.rs2, s.rd2, s);
        if (s.jump || s.ret) return s.pc4;
        if (s.aluop == 2'b00) return a + b;
        case (s.f3)
            3'd0: return (s.ins30 && !s.alusrc) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return s.ins30 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic m_taken(input stim_t s);
        logic [31:0] a, b;
        a = m_fwd(s.rs1, s.rd1, s);
        b = m_fwd(s.rs2, s.rd2, s);
        case (s.f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One non-stalling instruction through EX; called at posedge+1.
    task automatic run(input stim_t s, input string tag);
        logic        exp_redir;
        logic [31:0] exp_tgt, a;
        drive(s);
        #2;
        a = m_fwd(s.rs1, s.rd1, s);
        exp_redir = (s.branch && m_taken(s)) || s.jump || s.ret;
        exp_tgt = s.ret ? ((a + s.imm) & 32'hFFFF_FFFE) : s.pc + s.imm;
        obs_redirect = pc_redirect;
        obs_target = pc_target;
        check({tag, "_redirect"}, 32'(pc_redirect), 32'(exp_redir));
        check({tag, "_target"}, pc_target, exp_tgt);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        @(posedge clock);
        #1;
        if (s.aluop != 2'b01) check({tag, "_alu"}, MEM_ALUresult, m_result(s));
        check({tag, "_wdata"}, MEM_writedata, m_fwd(s.rs2, s.rd2, s));
        check({tag, "_rd_f3"}, {24'd0, MEM_funct3, MEM_rd}, {24'd0, s.f3, s.rd});
        check({tag, "_ctrl"}, {28'd0, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite},
              {28'd0, s.memread, s.memwrite, s.memtoreg, s.regwrite});
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = nop_stim();
        s.memread = 1'($urandom_range(0, 1)); s.memwrite = 1'($urandom_range(0, 1));
        s.memtoreg = 1'($urandom_range(0, 1)); s.regwrite = 1'($urandom_range(0, 1));
        s.ins30 = 1'($urandom_range(0, 1)); s.alusrc = 1'($urandom_range(0, 1));
        s.f3 = 3'($urandom_range(0, 7));
        s.pc = {14'd0, 16'($urandom()), 2'b00}; s.pc4 = s.pc + 32'd4;
        s.rd1 = rand_data(); s.rd2 = rand_data(); s.imm = rand_data();
        s.mdata = rand_data(); s.wdata = rand_data();
        s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom()); s.mrd = 5'($urandom_range(0, 3)); s.wrd = 5'($urandom_range(0, 3));
        s.mwe = 1'($urandom_range(0, 1)); s.wwe = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0: begin s.aluop = 2'b00; s.pcsel = 1'($urandom_range(0, 1)); end
            1: begin s.aluop = 2'b01; s.branch = 1'b1; s.alusrc = 1'b0; end
            2: s.aluop = 2'b10;
            default: begin
                s.aluop = 2'b00;
                if ($urandom_range(0, 1) == 1) begin s.jump = 1'b1; s.pcsel = 1'b1; end
                else s.ret = 1'b1;
            end
        endcase
        return s;
    endfunction

`ifdef RV_MULDIV_EN
    function automatic logic [31:0] m_mop(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * $signed({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic stim_t mop_stim(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        stim_t s;
        s = nop_stim();
        s.aluop = 2'b10; s.ins25 = 1'b1; s.f3 = f3; s.rd1 = a; s.rd2 = b;
        s.regwrite = 1'b1; s.rd = 5'd9;
        return s;
    endfunction

    // Full M-op: 33 stalled cycles of bubbles, then the result in EX/MEM.
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        int stalls = 0;
        bit done = 0;
        drive(mop_stim(f3, a, b));
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) stalls++;
            else done = 1;
            @(posedge clock);
            #1;
            if (!done) check({tag, "_bubble"}, 32'(MEM_RegWrite), 32'd0);
        end
        check({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
        check({tag, "_result"}, MEM_ALUresult, m_mop(f3, a, b));
        check({tag, "_regwrite"}, 32'(MEM_RegWrite), 32'd1);
    endtask
`endif

    initial begin
        stim_t s;
        reset_n = 1'b0;
        s = nop_stim();
        s.jump = 1'b1; s.regwrite = 1'b1; s.memread = 1'b1; s.rd1 = 32'h55;
`ifdef RV_MULDIV_EN
        s.aluop = 2'b10; s.ins25 = 1'b1;
`endif
        drive(s);
        #3;
        check("rst_redirect", 32'(pc_redirect), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ctrl", {28'd0, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite}, 32'd0);
        @(posedge clock);
        #1;
        check("rst_alu", MEM_ALUresult, 32'd0);
        check("rst_rd", {24'd0, MEM_funct3, MEM_rd}, 32'd0);
        reset_n = 1'b1;

        // Forwarding priority: MEM over WB over register file
        s = nop_stim();
        s.rs1 = 5'd5; s.rs2 = 5'd6; s.rd2 = 32'd3;
        s.mwe = 1'b1; s.mrd = 5'd5; s.mdata = 32'h10;
        s.wwe = 1'b1; s.wrd = 5'd5; s.wdata = 32'h20;
        run(s, "fwd_prio");
        check("fwd_prio_const", MEM_ALUresult, 32'h13);

        // x0 never forwards
        s = nop_stim();
        s.rs1 = 5'd0; s.mwe = 1'b1; s.mrd = 5'd0; s.mdata = 32'hDEAD;
        s.imm = 32'd7; s.alusrc = 1'b1;
        run(s, "x0");
        check("x0_const", MEM_ALUresult, 32'd7);

        // Signed vs unsigned branch on the same operands
        s = nop_stim();
        s.branch = 1'b1; s.aluop = 2'b01; s.f3 = 3'b100;
        s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.pc = 32'h100; s.pc4 = 32'h104; s.imm = 32'h20;
        run(s, "blt");
        check("blt_redirect_const", 32'(obs_redirect), 32'd1);
        check("blt_target_const", obs_target, 32'h120);
        s.f3 = 3'b110;
        run(s, "bltu");
        check("bltu_redirect_const", 32'(obs_redirect), 32'd0);

        // JALR: target LSB cleared, link value in EX/MEM
        s = nop_stim();
        s.ret = 1'b1; s.regwrite = 1'b1; s.alusrc = 1'b1;
        s.rd1 = 32'h1003; s.imm = 32'd4; s.pc = 32'h200; s.pc4 = 32'h204;
        run(s, "jalr");
        check("jalr_target_const", obs_target, 32'h1006);
        check("jalr_link_const", MEM_ALUresult, 32'h204);
        check("jalr_regwrite_const", 32'(MEM_RegWrite), 32'd1);

        // Arithmetic corner cases
        s = nop_stim();
        s.aluop = 2'b10; s.ins30 = 1'b1; s.f3 = 3'd0; s.rd1 = 32'd0; s.rd2 = 32'd1;
        run(s, "sub");
        check("sub_const", MEM_ALUresult, 32'hFFFF_FFFF);
        s.f3 = 3'd5; s.rd1 = 32'h8000_0000; s.rd2 = 32'd4;
        run(s, "sra");
        check("sra_const", MEM_ALUresult, 32'hF800_0000);
        s.ins30 = 1'b0; s.f3 = 3'd3; s.rd1 = 32'd1; s.rd2 = 32'hFFFF_FFFF;
        run(s, "sltu");
        check("sltu_const", MEM_ALUresult, 32'd1);

        for (int i = 0; i < 300; i++) begin
            run(rand_stim(), "rand");
        end

`ifdef RV_MULDIV_EN
        run_mop(3'd4, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        check("div_7_m2_const", MEM_ALUresult, 32'hFFFF_FFFD);
        run_mop(3'd5, 32'h1234_5678, 32'd0, "divu_by0");
        check("divu_by0_const", MEM_ALUresult, 32'hFFFF_FFFF);
        run_mop(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_mop(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_mop(3'd6, 32'hFFFF_FFF9, 32'd0, "rem_by0");
        for (int i = 0; i < 8; i++) begin
            run_mop(3'($urandom_range(0, 7)), rand_data(), rand_data(), "mop_rand");
        end

        // Reset in the middle of BUSY
        drive(mop_stim(3'd4, 32'd100, 32'd3));
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_regwrite", 32'(MEM_RegWrite), 32'd0);
        drive(nop_stim());
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run_mop(3'd5, 32'd100, 32'd3, "after_rst");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
